// File: rtl/rd_xfr_scheduler.sv
// rd_xfr_scheduler: queues trigger-tagged RD buffers and hands them to
// rd_interface one transfer at a time. It tracks which buffers hold
// complete data until software releases them, and it aborts a transfer
// that takes longer than XFR_TIMEOUT cycles.
module rd_xfr_scheduler #(
  parameter int unsigned XFR_TIMEOUT    = 1000000,
  parameter int unsigned TMO_WIDTH      = 20,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE_IN,
  input  logic        TRIG_IN,
  input  logic [1:0]  TRIG_BUF_IN,
  input  logic        XFR_DONE_IN,
  input  logic        RELEASE_IN,
  input  logic [1:0]  RELEASE_BUF_IN,
  input  logic        CLEAR_ERR_IN,
  output logic        ENABLE_XFR_OUT,
  output logic [1:0]  BUF_NUM_OUT,
  output logic [3:0]  BUF_READY_OUT,
  output logic        XFR_BUSY_OUT,
  output logic [31:0] STATUS
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_XFER    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TMO_WIDTH-1:0] TMO_LAST  = TMO_WIDTH'(XFR_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0][1:0]       fifo_mem_q, fifo_mem_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            fifo_cnt_q, fifo_cnt_d;
  logic [3:0]            pending_q, pending_d;
  logic [3:0]            ready_q, ready_d;
  logic                  enable_q, enable_d;
  logic [1:0]            buf_num_q, buf_num_d;
  logic [TMO_WIDTH-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [7:0]            tmo_count_q, tmo_count_d;
  logic                  sticky_q, sticky_d;

  logic push, pop, launch, can_pop, drop_inc, tmo_inc;

  // Next-state logic: release, then trigger admission, then FSM and FIFO pop.
  always_comb begin
    state_d     = state_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    pending_d   = pending_q;
    ready_d     = ready_q;
    enable_d    = enable_q;
    buf_num_d   = buf_num_q;
    tmo_cnt_d   = tmo_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    tmo_count_d = tmo_count_q;
    sticky_d    = sticky_q;
    push        = 1'b0;
    pop         = 1'b0;
    launch      = 1'b0;
    drop_inc    = 1'b0;
    tmo_inc     = 1'b0;
    can_pop     = ENABLE_IN && (fifo_cnt_q != '0);

    if (RELEASE_IN) begin
      ready_d[RELEASE_BUF_IN] = 1'b0;
    end

    // A buffer is admitted only if it is neither pending nor still ready.
    if (TRIG_IN && ENABLE_IN) begin
      if (!ready_d[TRIG_BUF_IN] && !pending_q[TRIG_BUF_IN]) begin
        push                   = 1'b1;
        pending_d[TRIG_BUF_IN] = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        launch = can_pop;
      end
      ST_ARM: begin
        state_d   = ST_XFER;
        tmo_cnt_d = '0;
      end
      ST_XFER: begin
        if (XFR_DONE_IN) begin
          ready_d[buf_num_q]   = 1'b1;
          pending_d[buf_num_q] = 1'b0;
          enable_d             = 1'b0;
          hold_cnt_d           = HOLD_LAST;
          state_d              = ST_HOLDOFF;
        end else if (tmo_cnt_q == TMO_LAST) begin
          pending_d[buf_num_q] = 1'b0;
          sticky_d             = 1'b1;
          tmo_inc              = 1'b1;
          enable_d             = 1'b0;
          hold_cnt_d           = HOLD_LAST;
          state_d              = ST_HOLDOFF;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // The last holdoff cycle doubles as the idle pop slot so the
        // enable gap between back-to-back transfers is exactly
        // HOLDOFF_CYCLES rather than one cycle longer.
        if (hold_cnt_q == '0) begin
          launch  = can_pop;
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      pop       = 1'b1;
      state_d   = ST_ARM;
      enable_d  = 1'b1;
      buf_num_d = fifo_mem_q[rd_ptr_q];
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = TRIG_BUF_IN;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (drop_inc && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    if (tmo_inc && (tmo_count_q != 8'hFF)) begin
      tmo_count_d = tmo_count_q + 8'd1;
    end
    if (CLEAR_ERR_IN) begin
      drop_cnt_d  = '0;
      tmo_count_d = '0;
      sticky_d    = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      fifo_mem_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      pending_q   <= '0;
      ready_q     <= '0;
      enable_q    <= 1'b0;
      buf_num_q   <= '0;
      tmo_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      tmo_count_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      enable_q    <= enable_d;
      buf_num_q   <= buf_num_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      tmo_count_q <= tmo_count_d;
      sticky_q    <= sticky_d;
    end
  end

  assign ENABLE_XFR_OUT = enable_q;
  assign BUF_NUM_OUT    = buf_num_q;
  assign BUF_READY_OUT  = ready_q;
  assign XFR_BUSY_OUT   = (state_q != ST_IDLE);
  assign STATUS         = {tmo_count_q, drop_cnt_q, ENABLE_IN, sticky_q, buf_num_q,
                           XFR_BUSY_OUT, fifo_cnt_q, pending_q, ready_q};

endmodule

// File: tb/tb_rd_xfr_scheduler.sv
// Testbench for rd_xfr_scheduler: directed table and sequences for the
// latency, ordering, drop, timeout and reset cases, followed by random
// traffic compared every cycle against a queue-based reference model.
module tb_rd_xfr_scheduler;

  localparam int H = 4;
  localparam int T = 16;

  logic        CLK;
  logic        RST;
  logic        ENABLE_IN;
  logic        TRIG_IN;
  logic [1:0]  TRIG_BUF_IN;
  logic        XFR_DONE_IN;
  logic        RELEASE_IN;
  logic [1:0]  RELEASE_BUF_IN;
  logic        CLEAR_ERR_IN;
  logic        ENABLE_XFR_OUT;
  logic [1:0]  BUF_NUM_OUT;
  logic [3:0]  BUF_READY_OUT;
  logic        XFR_BUSY_OUT;
  logic [31:0] STATUS;

  rd_xfr_scheduler #(
    .XFR_TIMEOUT(T),
    .TMO_WIDTH(5),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ENABLE_IN(ENABLE_IN),
    .TRIG_IN(TRIG_IN),
    .TRIG_BUF_IN(TRIG_BUF_IN),
    .XFR_DONE_IN(XFR_DONE_IN),
    .RELEASE_IN(RELEASE_IN),
    .RELEASE_BUF_IN(RELEASE_BUF_IN),
    .CLEAR_ERR_IN(CLEAR_ERR_IN),
    .ENABLE_XFR_OUT(ENABLE_XFR_OUT),
    .BUF_NUM_OUT(BUF_NUM_OUT),
    .BUF_READY_OUT(BUF_READY_OUT),
    .XFR_BUSY_OUT(XFR_BUSY_OUT),
    .STATUS(STATUS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: buffer sets as bitmaps, the request queue as a queue,
  // and a transfer described by how long the enable has been high and how
  // much of the cool-down remains.
  logic [3:0] m_ready, m_pend;
  logic [1:0] m_q[$];
  logic [1:0] m_buf;
  logic       m_on, m_sticky;
  int         m_age, m_cool, m_drop, m_tmo;

  task automatic m_reset();
    m_ready = '0; m_pend = '0; m_q.delete(); m_buf = '0; m_on = 1'b0;
    m_sticky = 1'b0; m_age = 0; m_cool = 0; m_drop = 0; m_tmo = 0;
  endtask

  task automatic m_step(input logic trig, input logic [1:0] tbuf, input logic done,
                        input logic rel, input logic [1:0] rbuf, input logic clr,
                        input logic rst);
    logic [3:0] r, p;
    logic acc, drop_hit, tmo_hit;
    int qsz;
    if (rst) begin
      m_reset();
      return;
    end
    r = m_ready; p = m_pend; qsz = m_q.size();
    acc = 1'b0; drop_hit = 1'b0; tmo_hit = 1'b0;
    if (rel) r[rbuf] = 1'b0;
    if (trig && ENABLE_IN) begin
      if (!r[tbuf] && !m_pend[tbuf]) acc = 1'b1;
      else drop_hit = 1'b1;
    end
    if (m_on) begin
      if (done && m_age >= 2) begin
        r[m_buf] = 1'b1; p[m_buf] = 1'b0; m_on = 1'b0; m_cool = H;
      end else if (m_age == T + 1) begin
        p[m_buf] = 1'b0; m_sticky = 1'b1; tmo_hit = 1'b1; m_on = 1'b0; m_cool = H;
      end else begin
        m_age++;
      end
    end else begin
      if (m_cool <= 1 && ENABLE_IN && qsz > 0) begin
        m_buf = m_q.pop_front(); m_on = 1'b1; m_age = 1;
      end
      if (m_cool > 0) m_cool--;
    end
    if (acc) begin
      m_q.push_back(tbuf);
      p[tbuf] = 1'b1;
    end
    if (drop_hit && m_drop < 255) m_drop++;
    if (tmo_hit && m_tmo < 255) m_tmo++;
    if (clr) begin
      m_drop = 0; m_tmo = 0; m_sticky = 1'b0;
    end
    m_ready = r; m_pend = p;
  endtask

  function automatic logic [31:0] m_status();
    logic m_busy;
    m_busy = m_on || (m_cool > 0);
    return {8'(m_tmo), 8'(m_drop), ENABLE_IN, m_sticky, m_buf, m_busy,
            3'(m_q.size()), m_pend, m_ready};
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic tick(input logic trig, input logic [1:0] tbuf, input logic done,
                      input logic rel, input logic [1:0] rbuf, input logic clr,
                      input logic rst);
    TRIG_IN = trig; TRIG_BUF_IN = tbuf; XFR_DONE_IN = done;
    RELEASE_IN = rel; RELEASE_BUF_IN = rbuf; CLEAR_ERR_IN = clr; RST = rst;
    m_step(trig, tbuf, done, rel, rbuf, clr, rst);
    @(posedge CLK);
    #1;
    chk("model_enable", ENABLE_XFR_OUT, m_on);
    chk("model_bufnum", BUF_NUM_OUT, m_buf);
    chk("model_ready", BUF_READY_OUT, m_ready);
    chk("model_busy", XFR_BUSY_OUT, (m_on || m_cool > 0));
    chk("model_status", STATUS, m_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wait_en(input string name);
    int n;
    n = 0;
    while (!ENABLE_XFR_OUT && n < 50) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    chk(name, ENABLE_XFR_OUT, 1'b1);
  endtask

  typedef struct {
    logic       trig;
    logic [1:0] tbuf;
    logic       done;
    logic       exp_en;
    logic [1:0] exp_buf;
    logic [3:0] exp_ready;
    logic       exp_busy;
  } vec_t;

  vec_t       t1 [13 + H];
  logic [1:0] order [3];
  int         hi, lo, k, cnt;

  initial begin
    ENABLE_IN = 1'b1; TRIG_IN = 1'b0; TRIG_BUF_IN = '0; XFR_DONE_IN = 1'b0;
    RELEASE_IN = 1'b0; RELEASE_BUF_IN = '0; CLEAR_ERR_IN = 1'b0; RST = 1'b1;
    m_reset();

    // Test 1: trigger buf 2 at cycle 0, done at cycle 10. Entry i holds the
    // inputs of cycle i and the outputs expected in cycle i+1.
    for (int i = 0; i < 13 + H; i++) begin
      int c;
      c = i + 1;
      t1[i].trig      = (i == 0);
      t1[i].tbuf      = 2'd2;
      t1[i].done      = (i == 10);
      t1[i].exp_en    = (c >= 2 && c <= 10);
      t1[i].exp_buf   = (c >= 2) ? 2'd2 : 2'd0;
      t1[i].exp_ready = (c >= 11) ? 4'b0100 : 4'b0000;
      t1[i].exp_busy  = (c >= 2 && c < 11 + H);
    end
    do_reset();
    chk("reset_status", STATUS, 32'h0000_8000);
    chk("reset_enable", ENABLE_XFR_OUT, 1'b0);
    chk("reset_busy", XFR_BUSY_OUT, 1'b0);
    for (int i = 0; i < 13 + H; i++) begin
      tick(t1[i].trig, t1[i].tbuf, t1[i].done, 0, 0, 0, 0);
      chk($sformatf("t1_en_c%0d", i + 1), ENABLE_XFR_OUT, t1[i].exp_en);
      chk($sformatf("t1_buf_c%0d", i + 1), BUF_NUM_OUT, t1[i].exp_buf);
      chk($sformatf("t1_ready_c%0d", i + 1), BUF_READY_OUT, t1[i].exp_ready);
      chk($sformatf("t1_busy_c%0d", i + 1), XFR_BUSY_OUT, t1[i].exp_busy);
    end

    // Test 2: three back-to-back transfers, done 5 cycles after each enable.
    do_reset();
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3;
    hi = 0; lo = 0; k = 0;
    for (int c = 0; c < 200 && !(k == 3 && !XFR_BUSY_OUT); c++) begin
      logic d;
      if (ENABLE_XFR_OUT) begin
        if (hi == 0) begin
          if (k < 3) chk("t2_order", BUF_NUM_OUT, order[k]);
          if (k > 0) chk("t2_gap", lo, H);
          k++;
        end
        hi++;
        lo = 0;
      end else begin
        hi = 0;
        lo++;
      end
      d = (hi == 6);
      tick(c < 3, (c < 3) ? order[c] : 2'd0, d, 0, 0, 0, 0);
    end
    chk("t2_count", k, 3);
    chk("t2_ready", STATUS[3:0], 4'b1011);

    // Test 3: trigger on a READY buffer drops; release+trigger is accepted.
    do_reset();
    tick(1, 2'd1, 0, 0, 0, 0, 0);
    wait_en("t3_first_enable");
    idle(2);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("t3_ready", BUF_READY_OUT, 4'b0010);
    idle(H + 2);
    tick(1, 2'd1, 0, 0, 0, 0, 0);
    chk("t3_drop", STATUS[23:16], 8'd1);
    chk("t3_nopend", STATUS[7:4], 4'b0000);
    idle(3);
    chk("t3_noxfr", ENABLE_XFR_OUT, 1'b0);
    tick(1, 2'd1, 0, 1, 2'd1, 0, 0);
    chk("t3_rel_ready", BUF_READY_OUT, 4'b0000);
    chk("t3_rel_pend", STATUS[7:4], 4'b0010);
    chk("t3_c1_en", ENABLE_XFR_OUT, 1'b0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("t3_c2_en", ENABLE_XFR_OUT, 1'b1);
    chk("t3_c2_buf", BUF_NUM_OUT, 2'd1);

    // Test 4: timeout after ARM plus T XFER cycles; then clear errors.
    do_reset();
    tick(1, 2'd0, 0, 0, 0, 0, 0);
    wait_en("t4_enable");
    cnt = 0;
    while (ENABLE_XFR_OUT && cnt < 100) begin
      cnt++;
      tick(0, 0, 0, 0, 0, 0, 0);
    end
    chk("t4_enable_cycles", cnt, T + 1);
    chk("t4_sticky", STATUS[14], 1'b1);
    chk("t4_tmo_count", STATUS[31:24], 8'd1);
    chk("t4_ready", BUF_READY_OUT, 4'b0000);
    chk("t4_pend", STATUS[7:4], 4'b0000);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("t4_clear", STATUS[31:14], 18'h2);

    // Test 5: reset in the middle of XFER, then a late done pulse.
    do_reset();
    tick(1, 2'd2, 0, 0, 0, 0, 0);
    wait_en("t5_enable");
    idle(3);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("t5_rst_status", STATUS, 32'h0000_8000);
    chk("t5_rst_enable", ENABLE_XFR_OUT, 1'b0);
    chk("t5_rst_buf", BUF_NUM_OUT, 2'd0);
    chk("t5_rst_busy", XFR_BUSY_OUT, 1'b0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("t5_late_done", BUF_READY_OUT, 4'b0000);
    chk("t5_late_en", ENABLE_XFR_OUT, 1'b0);

    // Test 6: triggers are ignored while globally disabled.
    ENABLE_IN = 1'b0;
    do_reset();
    tick(1, 2'd3, 0, 0, 0, 0, 0);
    idle(3);
    chk("t6_fifo", STATUS[10:8], 3'd0);
    chk("t6_drop", STATUS[23:16], 8'd0);
    chk("t6_en_bit", STATUS[15], 1'b0);
    chk("t6_enable", ENABLE_XFR_OUT, 1'b0);

    // Random traffic against the reference model.
    ENABLE_IN = 1'b1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (ENABLE_IN ? ($urandom_range(59) == 0) : ($urandom_range(9) == 0))
        ENABLE_IN = ~ENABLE_IN;
      tick($urandom_range(2) == 0, 2'($urandom_range(3)), $urandom_range(7) == 0,
           $urandom_range(4) == 0, 2'($urandom_range(3)), $urandom_range(39) == 0,
           $urandom_range(699) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
